// File: rtl/channel_in_group_acc.sv
// Accumulates adder-tree partial sums over several channel groups per pixel,
// realigning the input valid with the tree's fixed latency.
module channel_in_group_acc #(
    parameter int PICTURE_NUM  = 8,
    parameter int SUM_WIDTH    = 32,
    parameter int TREE_LATENCY = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [7:0]                       group_num,
    input  logic [15:0]                      pixel_num,
    input  logic                             valid_in,
    input  logic [PICTURE_NUM*SUM_WIDTH-1:0] sum_in,
    output logic [PICTURE_NUM*SUM_WIDTH-1:0] data_out,
    output logic                             valid_out,
    output logic                             busy,
    output logic                             done,
    output logic                             sat_flag
);

    localparam int W  = PICTURE_NUM * SUM_WIDTH;
    localparam int SW = SUM_WIDTH;
    localparam logic [SW-1:0] MAXV = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] MINV = {1'b1, {(SW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [TREE_LATENCY-1:0] r_vdly;
    logic [7:0]              r_gm1;
    logic [15:0]             r_pm1;
    logic [7:0]              r_grp_cnt;
    logic [15:0]             r_pix_cnt;
    logic [W-1:0]            r_acc;
    logic [W-1:0]            r_data_out;
    logic                    r_valid_out;
    logic                    r_sat;

    logic                    w_val;
    logic                    w_beat;
    logic                    w_first;
    logic                    w_last_grp;
    logic                    w_last_pix;
    logic                    w_emit;
    logic [W-1:0]            w_acc_nxt;
    logic [PICTURE_NUM-1:0]  w_clamp;

    assign w_val      = r_vdly[TREE_LATENCY-1];
    assign w_beat     = (r_state == S_RUN) && w_val && !start;
    assign w_first    = (r_grp_cnt == 8'd0);
    assign w_last_grp = (r_grp_cnt == r_gm1);
    assign w_last_pix = (r_pix_cnt == r_pm1);
    assign w_emit     = w_beat && w_last_grp;

    // One extra bit of headroom per lane exposes overflow for the clamp.
    for (genvar p = 0; p < PICTURE_NUM; p++) begin : g_lane
        logic [SW-1:0] w_a;
        logic [SW-1:0] w_b;
        logic [SW:0]   w_wide;
        logic          w_ovf;
        assign w_a    = r_acc[p*SW +: SW];
        assign w_b    = sum_in[p*SW +: SW];
        assign w_wide = {w_a[SW-1], w_a} + {w_b[SW-1], w_b};
        assign w_ovf  = w_wide[SW] ^ w_wide[SW-1];
        assign w_clamp[p] = !w_first && w_ovf;
        assign w_acc_nxt[p*SW +: SW] =
            w_first ? w_b :
            !w_ovf  ? w_wide[SW-1:0] :
            w_wide[SW] ? MINV : MAXV;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_RUN;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_RUN: begin
                    if (w_emit && w_last_pix) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vdly      <= '0;
            r_gm1       <= '0;
            r_pm1       <= '0;
            r_grp_cnt   <= '0;
            r_pix_cnt   <= '0;
            r_acc       <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_valid_out <= w_emit;
            if (start) begin
                r_vdly    <= '0;
                r_gm1     <= (group_num == 8'd0) ? 8'd0 : group_num - 8'd1;
                r_pm1     <= (pixel_num == 16'd0) ? 16'd0 : pixel_num - 16'd1;
                r_grp_cnt <= '0;
                r_pix_cnt <= '0;
                r_acc     <= '0;
                r_sat     <= 1'b0;
            end else begin
                r_vdly <= (r_vdly << 1) | TREE_LATENCY'(valid_in);
                if (w_beat) begin
                    r_acc <= w_acc_nxt;
                    r_sat <= r_sat | (|w_clamp);
                    if (w_last_grp) begin
                        r_grp_cnt  <= '0;
                        r_pix_cnt  <= w_last_pix ? 16'd0 : r_pix_cnt + 16'd1;
                        r_data_out <= w_acc_nxt;
                    end else begin
                        r_grp_cnt <= r_grp_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_channel_in_group_acc.sv
// Directed bench for channel_in_group_acc: table of accumulate vectors plus
// hand-written sequences for reset, restart and multi-pixel runs.
module tb_channel_in_group_acc;

    localparam int PN = 8;
    localparam int SW = 32;
    localparam int TL = 5;
    localparam int W  = PN * SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    group_num;
    logic [15:0]   pixel_num;
    logic          valid_in;
    logic [W-1:0]  sum_in;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          busy;
    logic          done;
    logic          sat_flag;

    logic [W-1:0]  tree_in;
    logic [W-1:0]  pipe [TL];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            q_cyc[$];
    logic [W-1:0]  q_dat[$];
    int            d_cyc[$];

    channel_in_group_acc #(
        .PICTURE_NUM(PN),
        .SUM_WIDTH(SW),
        .TREE_LATENCY(TL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .group_num(group_num),
        .pixel_num(pixel_num),
        .valid_in(valid_in),
        .sum_in(sum_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .busy(busy),
        .done(done),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Adder-tree stand-in: fixed TL-cycle delay of the presented beat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= tree_in;
        for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
    end
    assign sum_in = pipe[TL-1];

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                q_cyc.push_back(cyc);
                q_dat.push_back(data_out);
            end
            if (done) d_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [7:0]  g;
        logic [15:0] p;
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] e0;
        logic [31:0] e1;
        logic        sat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] a,
                                        input logic [31:0] b);
        logic [W-1:0] r;
        for (int p = 0; p < PN; p++) r[p*SW +: SW] = (p == 1) ? b : a;
        return r;
    endfunction

    task automatic clrq();
        q_cyc.delete();
        q_dat.delete();
        d_cyc.delete();
    endtask

    task automatic do_start(input logic [7:0] g, input logic [15:0] p);
        @(negedge clk);
        start = 1'b1;
        group_num = g;
        pixel_num = p;
        valid_in = 1'b0;
        tree_in = '0;
    endtask

    task automatic beat(input logic [W-1:0] v, output int t);
        @(negedge clk);
        start = 1'b0;
        valid_in = 1'b1;
        tree_in = v;
        t = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            valid_in = 1'b0;
            tree_in = '0;
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] g, input logic [15:0] p,
                           input logic [31:0] a0, a1, a2, a3,
                           input logic [31:0] b0, b1, b2, b3,
                           input logic [31:0] e0, e1, input logic s);
        vecs[i].g = g;
        vecs[i].p = p;
        vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2; vecs[i].a[3] = a3;
        vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2; vecs[i].b[3] = b3;
        vecs[i].e0 = e0;
        vecs[i].e1 = e1;
        vecs[i].sat = s;
    endtask

    initial begin
        int t;
        int tl [8];
        int geff;

        set_vec(0, 8'd4, 16'd1, 32'd1, 32'd2, 32'd3, 32'd4,
                -32'd1, -32'd2, -32'd3, -32'd4, 32'd10, -32'd10, 1'b0);
        set_vec(1, 8'd3, 16'd1, 32'd100, 32'd200, 32'd300, 32'd0,
                32'h7FFFFFFF, -32'd1, 32'd1, 32'd0, 32'd600, 32'h7FFFFFFF, 1'b0);
        set_vec(2, 8'd2, 16'd1, 32'h7FFFFFF0, 32'h20, 32'd0, 32'd0,
                32'h80000000, -32'd1, 32'd0, 32'd0, 32'h7FFFFFFF, 32'h80000000, 1'b1);
        set_vec(3, 8'd1, 16'd1, -32'd7, 32'd0, 32'd0, 32'd0,
                32'h12345678, 32'd0, 32'd0, 32'd0, -32'd7, 32'h12345678, 1'b0);
        set_vec(4, 8'd0, 16'd0, 32'd42, 32'd0, 32'd0, 32'd0,
                -32'd42, 32'd0, 32'd0, 32'd0, 32'd42, -32'd42, 1'b0);
        set_vec(5, 8'd3, 16'd1, 32'h7FFFFFFF, 32'd1, -32'd5, 32'd0,
                32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'd0,
                32'h7FFFFFFA, 32'hFFFFFFFF, 1'b1);

        rst = 1'b1;
        start = 1'b0;
        group_num = '0;
        pixel_num = '0;
        valid_in = 1'b0;
        tree_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_data", data_out, '0);
        chk("reset_flags", W'({valid_out, busy, done, sat_flag}), '0);
        rst = 1'b0;
        idle(TL + 1);

        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].g, vecs[i].p);
            clrq();
            geff = (vecs[i].g == 8'd0) ? 1 : int'(vecs[i].g);
            for (int k = 0; k < geff; k++) beat(mk(vecs[i].a[k], vecs[i].b[k]), t);
            idle(12);
            chk($sformatf("v%0d_count", i), W'(q_cyc.size()), W'(1));
            if (q_cyc.size() > 0) begin
                chk($sformatf("v%0d_data", i), q_dat[0], mk(vecs[i].e0, vecs[i].e1));
                chk($sformatf("v%0d_lat", i), W'(q_cyc[0]), W'(t + TL + 1));
            end
            chk($sformatf("v%0d_sat", i), W'(sat_flag), W'(vecs[i].sat));
            chk($sformatf("v%0d_done", i), W'(d_cyc.size()), W'(1));
            if (d_cyc.size() > 0 && q_cyc.size() > 0)
                chk($sformatf("v%0d_done_cyc", i), W'(d_cyc[0]), W'(q_cyc[0]));
            chk($sformatf("v%0d_busy", i), W'(busy), W'(0));
        end

        // Two pixels of four groups, back to back.
        do_start(8'd4, 16'd2);
        clrq();
        for (int k = 0; k < 8; k++) begin
            beat(mk(32'(k < 4 ? k + 1 : (k - 3) * 10), 32'(k < 4 ? k + 1 : (k - 3) * 10)), t);
            tl[k] = t;
        end
        idle(12);
        chk("p2_count", W'(q_cyc.size()), W'(2));
        if (q_cyc.size() == 2) begin
            chk("p2_pix0", q_dat[0], mk(32'd10, 32'd10));
            chk("p2_pix1", q_dat[1], mk(32'd100, 32'd100));
            chk("p2_lat0", W'(q_cyc[0]), W'(tl[3] + TL + 1));
            chk("p2_lat1", W'(q_cyc[1]), W'(tl[7] + TL + 1));
        end
        chk("p2_done", W'(d_cyc.size()), W'(1));
        if (d_cyc.size() > 0 && q_cyc.size() == 2)
            chk("p2_done_cyc", W'(d_cyc[0]), W'(q_cyc[1]));

        // Pass-through, three pixels at full rate.
        do_start(8'd1, 16'd3);
        clrq();
        beat(mk(32'd5, 32'd5), t);
        tl[0] = t;
        beat(mk(-32'd7, -32'd7), t);
        beat(mk(32'd9, 32'd9), t);
        idle(12);
        chk("g1_count", W'(q_cyc.size()), W'(3));
        if (q_cyc.size() == 3) begin
            chk("g1_o0", q_dat[0], mk(32'd5, 32'd5));
            chk("g1_o1", q_dat[1], mk(-32'd7, -32'd7));
            chk("g1_o2", q_dat[2], mk(32'd9, 32'd9));
            chk("g1_lat", W'(q_cyc[0]), W'(tl[0] + TL + 1));
            chk("g1_consec", W'(q_cyc[2] - q_cyc[0]), W'(2));
        end
        chk("g1_done", W'(d_cyc.size()), W'(1));
        chk("g1_busy", W'(busy), W'(0));

        // Restart with three beats still in the delay line.
        do_start(8'd2, 16'd1);
        clrq();
        beat(mk(32'd1000, 32'd1000), t);
        beat(mk(32'd2000, 32'd2000), t);
        beat(mk(32'd3000, 32'd3000), t);
        do_start(8'd2, 16'd1);
        beat(mk(32'd7, 32'd7), t);
        beat(mk(32'd8, 32'd8), t);
        idle(12);
        chk("rs_count", W'(q_cyc.size()), W'(1));
        if (q_cyc.size() > 0) begin
            chk("rs_data", q_dat[0], mk(32'd15, 32'd15));
            chk("rs_lat", W'(q_cyc[0]), W'(t + TL + 1));
        end

        // Reset in the middle of a run after two of four beats.
        do_start(8'd4, 16'd1);
        beat(mk(32'd500, 32'd500), t);
        beat(mk(32'd600, 32'd600), t);
        idle(1);
        chk("mid_busy", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_data", data_out, '0);
        chk("mid_rst_flags", W'({valid_out, busy, done, sat_flag}), '0);
        @(negedge clk);
        rst = 1'b0;
        clrq();
        do_start(8'd4, 16'd1);
        for (int k = 0; k < 4; k++) beat(mk(32'(k + 1), 32'(k + 1)), t);
        idle(12);
        chk("mid_count", W'(q_cyc.size()), W'(1));
        if (q_cyc.size() > 0) chk("mid_data", q_dat[0], mk(32'd10, 32'd10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
